// File: rtl/hx8352_pkg.sv
// Shared HX8352 bus definitions: index map, rs encodings, default panel size,
// and the window/pointer types used by the responder and the controller.
package hx8352_pkg;

  localparam logic [7:0] IDX_GRAM = 8'h22;
  localparam logic [7:0] IDX_XS_H = 8'h02;
  localparam logic [7:0] IDX_XS_L = 8'h03;
  localparam logic [7:0] IDX_XE_H = 8'h04;
  localparam logic [7:0] IDX_XE_L = 8'h05;
  localparam logic [7:0] IDX_YS_H = 8'h06;
  localparam logic [7:0] IDX_YS_L = 8'h07;
  localparam logic [7:0] IDX_YE_H = 8'h08;
  localparam logic [7:0] IDX_YE_L = 8'h09;

  localparam logic LCD_CMD  = 1'b0;
  localparam logic LCD_DATA = 1'b1;

  localparam int DEF_H_RES = 240;
  localparam int DEF_V_RES = 400;

  typedef struct packed {
    logic [8:0] x0;
    logic [8:0] x1;
    logic [8:0] y0;
    logic [8:0] y1;
  } win_t;

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
  } ptr_t;

  // Window coordinates are split across an H register (bit 8) and an L register.
  function automatic logic [8:0] win_upd(input logic [8:0] cur, input logic hi,
                                         input logic [7:0] d);
    return hi ? {d[0], cur[7:0]} : {cur[8], d};
  endfunction

endpackage

// File: rtl/hx8352_bus_sync.sv
// Multi-stage synchronizer with rise/fall detect on the synchronized stage.
// Edges are held off until the chain holds only post-reset samples.
module hx8352_bus_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_rise,
  output logic [W-1:0] o_fall
);

  logic [STAGES:0][W-1:0] r_chain;
  logic [STAGES:0]        r_warm;
  logic [W-1:0]           w_prev;
  logic [W-1:0]           w_en;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '1;
      r_warm  <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-1:0], i_d};
      r_warm  <= {r_warm[STAGES-1:0], 1'b1};
    end
  end

  assign o_q    = r_chain[STAGES-1];
  assign w_prev = r_chain[STAGES];
  assign w_en   = {W{r_warm[STAGES]}};
  assign o_rise = o_q & ~w_prev & w_en;
  assign o_fall = ~o_q & w_prev & w_en;

endmodule

// File: rtl/hx8352_bus_responder.sv
// HX8352 panel-side responder: decodes 8080-style index/data writes into a
// register file, window and GRAM pixel stream, and answers register reads.
import hx8352_pkg::*;

module hx8352_bus_responder #(
  parameter int H_RES       = DEF_H_RES,
  parameter int V_RES       = DEF_V_RES,
  parameter int SYNC_STAGES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lcd_cs,
  input  logic        i_lcd_rs,
  input  logic        i_lcd_wr,
  input  logic        i_lcd_rd,
  input  logic        i_lcd_rst,
  input  logic [15:0] i_data_in,
  output logic [15:0] o_data_out,
  output logic        o_data_oe,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_index,
  output logic        o_reg_wr_valid,
  output logic        o_pixel_valid,
  output logic [8:0]  o_pixel_x,
  output logic [8:0]  o_pixel_y,
  output logic [15:0] o_pixel_data,
  output logic        o_frame_done,
  output logic        o_protocol_err
);

  localparam int VW = 19;
  localparam win_t WIN_RST = '{x0: 9'd0, x1: 9'(H_RES - 1), y0: 9'd0, y1: 9'(V_RES - 1)};

  logic [VW-1:0] w_vec_raw, w_vec_q, w_vec_rise, w_vec_fall;
  logic          w_wr_s, w_wr_rise, w_wr_fall;
  logic          w_rd_s, w_rd_rise, w_rd_fall;
  logic          w_lrst_s, w_cs_s, w_rs_s;
  logic [15:0]   w_data_s;
  logic          w_wr_evt, w_rd_evt, w_both;

  assign w_vec_raw = {i_lcd_rst, i_lcd_cs, i_lcd_rs, i_data_in};

  hx8352_bus_sync #(.W(VW), .STAGES(SYNC_STAGES)) u_sync_vec (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(w_vec_raw),
    .o_q(w_vec_q), .o_rise(w_vec_rise), .o_fall(w_vec_fall)
  );

  hx8352_bus_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_wr (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_lcd_wr),
    .o_q(w_wr_s), .o_rise(w_wr_rise), .o_fall(w_wr_fall)
  );

  hx8352_bus_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_rd (
    .i_clk(i_clk), .i_rst(i_rst), .i_d(i_lcd_rd),
    .o_q(w_rd_s), .o_rise(w_rd_rise), .o_fall(w_rd_fall)
  );

  assign w_lrst_s = w_vec_q[18];
  assign w_cs_s   = w_vec_q[17];
  assign w_rs_s   = w_vec_q[16];
  assign w_data_s = w_vec_q[15:0];

  assign w_wr_evt = w_wr_rise & ~w_cs_s;
  assign w_rd_evt = w_rd_fall & ~w_cs_s;
  assign w_both   = ~w_wr_s & ~w_rd_s;

  logic [7:0]            r_index;
  logic [255:0][7:0]     r_regs;
  win_t                  r_win;
  ptr_t                  r_ptr;
  logic [15:0]           r_data_out;
  logic                  r_data_oe;
  logic                  r_cmd_valid, r_reg_wr_valid, r_pixel_valid, r_frame_done;
  logic [8:0]            r_pix_x, r_pix_y;
  logic [15:0]           r_pix_data;
  logic                  r_protocol_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_index        <= '0;
      r_regs         <= '0;
      r_win          <= WIN_RST;
      r_ptr          <= '0;
      r_data_out     <= '0;
      r_data_oe      <= 1'b0;
      r_cmd_valid    <= 1'b0;
      r_reg_wr_valid <= 1'b0;
      r_pixel_valid  <= 1'b0;
      r_frame_done   <= 1'b0;
      r_pix_x        <= '0;
      r_pix_y        <= '0;
      r_pix_data     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      r_cmd_valid    <= 1'b0;
      r_reg_wr_valid <= 1'b0;
      r_pixel_valid  <= 1'b0;
      r_frame_done   <= 1'b0;
      if (w_both) r_protocol_err <= 1'b1;

      // Panel reset holds register state at defaults and swallows every event.
      if (!w_lrst_s) begin
        r_index   <= '0;
        r_regs    <= '0;
        r_win     <= WIN_RST;
        r_ptr     <= '0;
        r_data_oe <= 1'b0;
      end else begin
        if (w_wr_evt) begin
          if (w_rs_s == LCD_CMD) begin
            r_index     <= w_data_s[7:0];
            r_cmd_valid <= 1'b1;
            if (w_data_s[7:0] == IDX_GRAM) r_ptr <= '{x: r_win.x0, y: r_win.y0};
          end else if (r_index != IDX_GRAM) begin
            r_regs[r_index] <= w_data_s[7:0];
            r_reg_wr_valid  <= 1'b1;
            case (r_index)
              IDX_XS_H: r_win.x0 <= win_upd(r_win.x0, 1'b1, w_data_s[7:0]);
              IDX_XS_L: r_win.x0 <= win_upd(r_win.x0, 1'b0, w_data_s[7:0]);
              IDX_XE_H: r_win.x1 <= win_upd(r_win.x1, 1'b1, w_data_s[7:0]);
              IDX_XE_L: r_win.x1 <= win_upd(r_win.x1, 1'b0, w_data_s[7:0]);
              IDX_YS_H: r_win.y0 <= win_upd(r_win.y0, 1'b1, w_data_s[7:0]);
              IDX_YS_L: r_win.y0 <= win_upd(r_win.y0, 1'b0, w_data_s[7:0]);
              IDX_YE_H: r_win.y1 <= win_upd(r_win.y1, 1'b1, w_data_s[7:0]);
              IDX_YE_L: r_win.y1 <= win_upd(r_win.y1, 1'b0, w_data_s[7:0]);
              default: ;
            endcase
          end else begin
            r_pixel_valid <= 1'b1;
            r_pix_x       <= r_ptr.x;
            r_pix_y       <= r_ptr.y;
            r_pix_data    <= w_data_s;
            if (r_ptr.x >= r_win.x1) begin
              r_ptr.x <= r_win.x0;
              if (r_ptr.y >= r_win.y1) begin
                r_ptr.y      <= r_win.y0;
                r_frame_done <= 1'b1;
              end else begin
                r_ptr.y <= r_ptr.y + 9'd1;
              end
            end else begin
              r_ptr.x <= r_ptr.x + 9'd1;
            end
          end
        end

        // A conflicting strobe pair or a deselect always wins over a read.
        if (w_both || w_cs_s || w_rd_rise) begin
          r_data_oe <= 1'b0;
        end else if (w_rd_evt) begin
          r_data_oe  <= 1'b1;
          r_data_out <= (w_rs_s == LCD_DATA) ? {8'h00, r_regs[r_index]} : {8'h00, r_index};
        end
      end
    end
  end

  assign o_data_out     = r_data_out;
  assign o_data_oe      = r_data_oe;
  assign o_cmd_valid    = r_cmd_valid;
  assign o_cmd_index    = r_index;
  assign o_reg_wr_valid = r_reg_wr_valid;
  assign o_pixel_valid  = r_pixel_valid;
  assign o_pixel_x      = r_pix_x;
  assign o_pixel_y      = r_pix_y;
  assign o_pixel_data   = r_pix_data;
  assign o_frame_done   = r_frame_done;
  assign o_protocol_err = r_protocol_err;

endmodule

// File: tb/tb_hx8352_bus_responder.sv
// Directed + randomized bench for hx8352_bus_responder against a behavioural
// panel model (register array, window bytes, integer pixel pointer).
module tb_hx8352_bus_responder;

  localparam int H_RES = 240;
  localparam int V_RES = 400;
  localparam int SS    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lcd_cs = 1'b1, lcd_rs = 1'b1, lcd_wr = 1'b1, lcd_rd = 1'b1, lcd_rst = 1'b1;
  logic [15:0] data_in = '0;
  logic [15:0] o_data_out, o_pixel_data;
  logic        o_data_oe, o_cmd_valid, o_reg_wr_valid, o_pixel_valid, o_frame_done, o_protocol_err;
  logic [7:0]  o_cmd_index;
  logic [8:0]  o_pixel_x, o_pixel_y;

  hx8352_bus_responder #(.H_RES(H_RES), .V_RES(V_RES), .SYNC_STAGES(SS)) dut (
    .i_clk(clk), .i_rst(rst), .i_lcd_cs(lcd_cs), .i_lcd_rs(lcd_rs), .i_lcd_wr(lcd_wr),
    .i_lcd_rd(lcd_rd), .i_lcd_rst(lcd_rst), .i_data_in(data_in),
    .o_data_out(o_data_out), .o_data_oe(o_data_oe), .o_cmd_valid(o_cmd_valid),
    .o_cmd_index(o_cmd_index), .o_reg_wr_valid(o_reg_wr_valid), .o_pixel_valid(o_pixel_valid),
    .o_pixel_x(o_pixel_x), .o_pixel_y(o_pixel_y), .o_pixel_data(o_pixel_data),
    .o_frame_done(o_frame_done), .o_protocol_err(o_protocol_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Panel model
  logic [7:0]  m_regs [256];
  int          m_win [10];
  logic [7:0]  m_index;
  int          m_px, m_py;
  bit          m_prst;
  bit          e_cmd, e_regw, e_pix, e_fd;
  int          e_px, e_py;
  logic [15:0] e_pd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int wv(input int hi);
    return (m_win[hi] & 1) * 256 + m_win[hi+1];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_regs[i] = 8'h00;
    for (int i = 0; i < 10; i++) m_win[i] = 0;
    m_win[4] = (H_RES - 1) / 256;  m_win[5] = (H_RES - 1) % 256;
    m_win[8] = (V_RES - 1) / 256;  m_win[9] = (V_RES - 1) % 256;
    m_index = 8'h00; m_px = 0; m_py = 0;
  endtask

  task automatic model_write(input logic cs, input logic rs, input logic [15:0] d);
    e_cmd = 0; e_regw = 0; e_pix = 0; e_fd = 0;
    if (!cs && !m_prst) begin
      if (!rs) begin
        m_index = d[7:0]; e_cmd = 1;
        if (m_index == 8'h22) begin m_px = wv(2); m_py = wv(6); end
      end else if (m_index != 8'h22) begin
        m_regs[m_index] = d[7:0]; e_regw = 1;
        if (m_index >= 2 && m_index <= 9) m_win[m_index] = int'(d[7:0]);
      end else begin
        e_pix = 1; e_px = m_px; e_py = m_py; e_pd = d;
        if (m_px >= wv(4)) begin
          m_px = wv(2);
          if (m_py >= wv(8)) begin m_py = wv(6); e_fd = 1; end
          else m_py++;
        end else m_px++;
      end
    end
  endtask

  task automatic bus_write(input logic cs, input logic rs, input logic [15:0] d);
    @(negedge clk);
    lcd_cs = cs; lcd_rs = rs; data_in = d; lcd_wr = 1'b0;
    repeat (4) @(negedge clk);
    lcd_wr = 1'b1;
    model_write(cs, rs, d);
    repeat (SS) @(negedge clk);
    chk("pulse_early", {o_cmd_valid, o_reg_wr_valid, o_pixel_valid, o_frame_done}, 0);
    @(negedge clk);
    chk("cmd_valid", o_cmd_valid, e_cmd);
    chk("reg_wr_valid", o_reg_wr_valid, e_regw);
    chk("pixel_valid", o_pixel_valid, e_pix);
    chk("frame_done", o_frame_done, e_fd);
    chk("cmd_index", o_cmd_index, m_index);
    if (e_pix) begin
      chk("pixel_x", o_pixel_x, e_px);
      chk("pixel_y", o_pixel_y, e_py);
      chk("pixel_data", o_pixel_data, e_pd);
    end
    @(negedge clk);
    lcd_cs = 1'b1;
  endtask

  task automatic bus_read(input logic rs);
    logic [15:0] exp;
    @(negedge clk);
    lcd_cs = 1'b0; lcd_rs = rs; lcd_rd = 1'b0;
    exp = rs ? {8'h00, m_regs[m_index]} : {8'h00, m_index};
    repeat (SS) @(negedge clk);
    chk("oe_early", o_data_oe, 0);
    @(negedge clk);
    chk("data_oe", o_data_oe, 1);
    chk("data_out", o_data_out, exp);
    @(negedge clk);
    lcd_rd = 1'b1;
    repeat (SS) @(negedge clk);
    chk("oe_hold", o_data_oe, 1);
    @(negedge clk);
    chk("oe_drop", o_data_oe, 0);
    @(negedge clk);
    lcd_cs = 1'b1;
  endtask

  task automatic wreg(input logic [7:0] idx, input logic [7:0] val);
    bus_write(1'b0, 1'b0, {8'h00, idx});
    bus_write(1'b0, 1'b1, {8'h00, val});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_outs"}, {o_data_oe, o_cmd_valid, o_reg_wr_valid, o_pixel_valid,
                         o_frame_done, o_protocol_err}, 0);
    chk({tag, "_index"}, o_cmd_index, 0);
    chk({tag, "_dout"}, o_data_out, 0);
    chk({tag, "_pix"}, {o_pixel_x, o_pixel_y, o_pixel_data}, 0);
  endtask

  initial begin
    m_prst = 0;
    model_reset();
    // Reset state
    repeat (3) @(negedge clk);
    chk_idle("in_rst");
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk_idle("post_rst");
    bus_write(1'b0, 1'b0, 16'h0022);
    bus_write(1'b0, 1'b1, 16'h1234);
    chk("first_pixel_origin", {o_pixel_x, o_pixel_y}, 0);

    // Register write and readback
    bus_write(1'b0, 1'b0, 16'h0083);
    bus_write(1'b0, 1'b1, 16'h0002);
    bus_read(1'b1);
    chk("reg83_readback", o_data_out, 16'h0002);
    bus_read(1'b0);

    // Wrapping window
    wreg(8'h02, 8'h00); wreg(8'h03, 8'h0A);
    wreg(8'h04, 8'h00); wreg(8'h05, 8'h0B);
    wreg(8'h06, 8'h01); wreg(8'h07, 8'h0F);
    wreg(8'h08, 8'h01); wreg(8'h09, 8'h10);
    bus_write(1'b0, 1'b0, 16'h0022);
    for (int k = 1; k <= 5; k++) bus_write(1'b0, 1'b1, 16'hAA00 + 16'(k));

    // Chip select high is ignored
    bus_write(1'b0, 1'b0, 16'h0005);
    bus_write(1'b1, 1'b1, 16'h00FF);
    bus_read(1'b1);
    bus_write(1'b1, 1'b0, 16'h0022);
    bus_write(1'b0, 1'b0, 16'h0022);
    for (int k = 0; k < 3; k++) bus_write(1'b0, 1'b1, 16'hBB00 + 16'(k));

    // Simultaneous strobes
    bus_write(1'b0, 1'b0, 16'h0040);
    @(negedge clk);
    lcd_cs = 1'b0; lcd_rs = 1'b1; data_in = 16'h0055; lcd_wr = 1'b0; lcd_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("perr_set", o_protocol_err, 1);
    chk("oe_suppressed", o_data_oe, 0);
    lcd_wr = 1'b1; lcd_rd = 1'b1;
    model_write(1'b0, 1'b1, 16'h0055);
    repeat (SS + 1) @(negedge clk);
    chk("both_write_done", o_reg_wr_valid, e_regw);
    @(negedge clk); lcd_cs = 1'b1;
    lcd_rst = 1'b0; m_prst = 1; model_reset();
    repeat (6) @(negedge clk);
    lcd_rst = 1'b1; m_prst = 0;
    repeat (6) @(negedge clk);
    chk("perr_kept_lcd_rst", o_protocol_err, 1);
    bus_write(1'b0, 1'b0, 16'h0040);
    bus_read(1'b1);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk); rst = 1'b0; model_reset();
    repeat (5) @(negedge clk);
    chk("perr_cleared_rst", o_protocol_err, 0);

    // Reset mid-stream
    wreg(8'h05, 8'h03); wreg(8'h09, 8'h02);
    bus_write(1'b0, 1'b0, 16'h0022);
    bus_write(1'b0, 1'b1, 16'hC001);
    bus_write(1'b0, 1'b1, 16'hC002);
    @(negedge clk); lcd_rst = 1'b0; m_prst = 1; model_reset();
    repeat (5) @(negedge clk);
    bus_write(1'b0, 1'b1, 16'hC003);
    bus_write(1'b0, 1'b0, 16'h0005);
    repeat (2) @(negedge clk);
    lcd_rst = 1'b1; m_prst = 0;
    repeat (5) @(negedge clk);
    chk("lrst_index", o_cmd_index, 0);
    bus_write(1'b0, 1'b0, 16'h0005);
    bus_read(1'b1);
    bus_write(1'b0, 1'b0, 16'h0022);
    for (int k = 0; k < H_RES + 1; k++) bus_write(1'b0, 1'b1, 16'(k * 7));
    chk("row_wrap_y", {o_pixel_x, o_pixel_y}, {9'd0, 9'd1});

    // Reset with a read in flight
    @(negedge clk); lcd_cs = 1'b0; lcd_rs = 1'b1; lcd_rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("oe_before_rst", o_data_oe, 1);
    rst = 1'b1;
    #1 chk("oe_rst_async", o_data_oe, 0);
    repeat (2) @(negedge clk);
    lcd_rd = 1'b1; lcd_cs = 1'b1;
    @(negedge clk); rst = 1'b0; model_reset();
    repeat (5) @(negedge clk);

    // Randomized traffic
    for (int n = 0; n < 80; n++) begin
      int op;
      logic [7:0] idx;
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        if ($urandom_range(0, 3) == 0) idx = 8'h22;
        else if ($urandom_range(0, 1) == 1) idx = 8'($urandom_range(2, 9));
        else idx = 8'($urandom);
        bus_write(1'b0, 1'b0, {8'h00, idx});
      end else if (op <= 6) begin
        bus_write(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0, 1'b1, 16'($urandom));
      end else begin
        bus_read(op != 9);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
